// File: rtl/param_trigger_cache_pkg.sv
// Shared FSM encoding and reset constants for the trigger-surround capture block.
package param_trigger_cache_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StRunning = 2'd1;
  localparam state_t StPost    = 2'd2;
  localparam state_t StSend    = 2'd3;

  localparam state_t StateRst = StIdle;
  localparam logic   FlagRst  = 1'b0;

endpackage

// File: rtl/ptc_ring_ram.sv
// Ring buffer storage: one write port and one registered read port; contents are not reset.
module ptc_ring_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_trigger_cache.sv
// Trigger-surround ADC capture into a ring buffer, then MSB-first serial readout of the window.
// Optional rising-edge trigger qualification: define PARAM_TRIGGER_CACHE_EDGE_TRIG_EN.
module param_trigger_cache
  import param_trigger_cache_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned TIMER_W = 32,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic               adc_valid,
  input  logic [DATA_W-1:0]  threshold,
  input  logic [PTR_W-1:0]   pre_count,
  output logic               trd,
  output logic               cd,
  output logic [TIMER_W-1:0] trigtm,
  output logic               sd,
  output logic               sd_valid,
  output logic               busy
);

  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned FILL_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]  PtrLast  = PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FillFull = FILL_W'(DEPTH);
  localparam logic [BIT_W-1:0]  BitLast  = BIT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    pre_q, pre_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    trig_ptr_q, trig_ptr_d;
  logic [PTR_W-1:0]    post_cnt_q, post_cnt_d;
  logic [PTR_W-1:0]    word_cnt_q, word_cnt_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [TIMER_W-1:0]  trigtm_q, trigtm_d;
  logic                trd_q, trd_d;
  logic                cd_q, cd_d;
  logic                sd_valid_q, sd_valid_d;

  logic                ram_we;
  logic                ram_re;
  logic [DATA_W-1:0]   ram_rdata;
  logic [DATA_W-1:0]   cur_word;
  logic                level_hit;
  logic                trig_hit;

  ptc_ring_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (adc_data),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign ram_we    = adc_valid && ((state_q == StRunning) || (state_q == StPost));
  assign level_hit = adc_valid && (adc_data >= threshold) && (fill_cnt_q >= {1'b0, pre_q});

`ifdef PARAM_TRIGGER_CACHE_EDGE_TRIG_EN
  // Set only after a valid sample below threshold, so the first sample after start cannot fire.
  logic prev_below_q, prev_below_d;
  assign trig_hit = level_hit && prev_below_q;
`else
  assign trig_hit = level_hit;
`endif

  // First bit of each word comes straight from the RAM output; the rest from the shifter.
  assign cur_word = (bit_idx_q == '0) ? ram_rdata : shift_q;

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    trig_ptr_d = trig_ptr_q;
    post_cnt_d = post_cnt_q;
    word_cnt_d = word_cnt_q;
    fill_cnt_d = fill_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    timer_d    = timer_q;
    trigtm_d   = trigtm_q;
    trd_d      = trd_q;
    cd_d       = cd_q;
    sd_valid_d = sd_valid_q;
    ram_re     = 1'b0;
`ifdef PARAM_TRIGGER_CACHE_EDGE_TRIG_EN
    prev_below_d = prev_below_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRunning;
          pre_d      = pre_count;
          trd_d      = 1'b0;
          cd_d       = 1'b0;
          trigtm_d   = '0;
          wr_ptr_d   = '0;
          fill_cnt_d = '0;
          timer_d    = '0;
`ifdef PARAM_TRIGGER_CACHE_EDGE_TRIG_EN
          prev_below_d = 1'b0;
`endif
        end
      end

      StRunning: begin
        timer_d = timer_q + TIMER_W'(1);
        if (adc_valid) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (fill_cnt_q < FillFull) fill_cnt_d = fill_cnt_q + FILL_W'(1);
`ifdef PARAM_TRIGGER_CACHE_EDGE_TRIG_EN
          prev_below_d = (adc_data < threshold);
`endif
        end
        if (trig_hit) begin
          trig_ptr_d = wr_ptr_q;
          trigtm_d   = timer_q;
          trd_d      = 1'b1;
          post_cnt_d = PtrLast - pre_q;
          if (pre_q == PtrLast) begin
            state_d  = StSend;
            rd_ptr_d = wr_ptr_q - pre_q;
          end else begin
            state_d = StPost;
          end
        end
      end

      StPost: begin
        if (adc_valid) begin
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
          post_cnt_d = post_cnt_q - PTR_W'(1);
          if (post_cnt_q == PTR_W'(1)) begin
            state_d  = StSend;
            rd_ptr_d = trig_ptr_q - pre_q;
          end
        end
      end

      StSend: begin
        if (!sd_valid_q) begin
          // Prefetch cycle: the first word lands on the RAM output as the first bit goes out.
          ram_re     = 1'b1;
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
          sd_valid_d = 1'b1;
          bit_idx_d  = '0;
          word_cnt_d = '0;
        end else begin
          shift_d = cur_word << 1;
          if (bit_idx_q == BitLast) begin
            bit_idx_d = '0;
            if (word_cnt_q == PtrLast) begin
              sd_valid_d = 1'b0;
              cd_d       = 1'b1;
              state_d    = StIdle;
            end else begin
              word_cnt_d = word_cnt_q + PTR_W'(1);
              ram_re     = 1'b1;
              rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StateRst;
      pre_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      trig_ptr_q <= '0;
      post_cnt_q <= '0;
      word_cnt_q <= '0;
      fill_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      timer_q    <= '0;
      trigtm_q   <= '0;
      trd_q      <= FlagRst;
      cd_q       <= FlagRst;
      sd_valid_q <= FlagRst;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      post_cnt_q <= post_cnt_d;
      word_cnt_q <= word_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      trigtm_q   <= trigtm_d;
      trd_q      <= trd_d;
      cd_q       <= cd_d;
      sd_valid_q <= sd_valid_d;
    end
  end

`ifdef PARAM_TRIGGER_CACHE_EDGE_TRIG_EN
  always_ff @(posedge clk) begin
    if (reset) prev_below_q <= FlagRst;
    else       prev_below_q <= prev_below_d;
  end
`endif

  assign trd      = trd_q;
  assign cd       = cd_q;
  assign trigtm   = trigtm_q;
  assign sd_valid = sd_valid_q;
  assign sd       = sd_valid_q & cur_word[DATA_W-1];
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_param_trigger_cache.sv
// Randomized and directed bench for param_trigger_cache against a sample-list reference model.
module tb_param_trigger_cache;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 32;
  localparam int TIMER_W = 32;
  localparam int PTR_W   = 5;
  localparam int MAXC    = 512;
  localparam int NBITS   = DEPTH * DATA_W;
`ifdef PARAM_TRIGGER_CACHE_EDGE_TRIG_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic               start;
  logic [DATA_W-1:0]  adc_data;
  logic               adc_valid;
  logic [DATA_W-1:0]  threshold;
  logic [PTR_W-1:0]   pre_count;
  logic               trd;
  logic               cd;
  logic [TIMER_W-1:0] trigtm;
  logic               sd;
  logic               sd_valid;
  logic               busy;

  param_trigger_cache #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMER_W (TIMER_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .threshold (threshold),
    .pre_count (pre_count),
    .trd       (trd),
    .cd        (cd),
    .trigtm    (trigtm),
    .sd        (sd),
    .sd_valid  (sd_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] samp [MAXC];
  bit         vld  [MAXC];
  logic [7:0] exp_win [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the accepted samples as a plain list; the window is a slice of that list.
  task automatic model(input int pre, input int thr, output int trig_c, output int done_c,
                       output bit ok);
    int         k;
    int         post;
    int         trig_k;
    int         fill;
    bit         edge_ok;
    logic [7:0] hist [MAXC];
    k = 0; post = 0; trig_k = -1; ok = 1'b0; trig_c = -1; done_c = -1;
    for (int c = 0; c < MAXC; c++) begin
      if (!vld[c]) continue;
      if (trig_k < 0) begin
        edge_ok = !EDGE || (k > 0 && int'(hist[k-1]) < thr);
        fill = (k < DEPTH) ? k : DEPTH;
        if (int'(samp[c]) >= thr && fill >= pre && edge_ok) begin
          trig_k = k;
          trig_c = c;
          post   = DEPTH - 1 - pre;
        end
      end else begin
        post--;
      end
      hist[k] = samp[c];
      k++;
      if (trig_k >= 0 && post == 0) begin
        done_c = c;
        ok = 1'b1;
        break;
      end
    end
    if (ok) for (int i = 0; i < DEPTH; i++) exp_win[i] = hist[trig_k - pre + i];
  endtask

  task automatic gen_ramp();
    for (int c = 0; c < MAXC; c++) begin
      vld[c]  = 1'b1;
      samp[c] = 8'(c);
    end
  endtask

  task automatic gen_const(input logic [7:0] v);
    for (int c = 0; c < MAXC; c++) begin
      vld[c]  = 1'b1;
      samp[c] = v;
    end
  endtask

  task automatic gen_random();
    for (int c = 0; c < MAXC; c++) begin
      vld[c]  = ($urandom_range(9) < 7);
      samp[c] = 8'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trd"},    32'(trd),      32'd0);
    check({tag, "_cd"},     32'(cd),       32'd0);
    check({tag, "_sdv"},    32'(sd_valid), 32'd0);
    check({tag, "_sd"},     32'(sd),       32'd0);
    check({tag, "_busy"},   32'(busy),     32'd0);
    check({tag, "_trigtm"}, trigtm,        32'd0);
  endtask

  // Called one cycle after an edge with the DUT in IDLE; abort_bit < 0 runs to completion.
  task automatic run_capture(input string tag, input int pre, input int thr, input int abort_bit);
    int         trig_c;
    int         done_c;
    int         bad_v;
    bit         ok;
    logic [7:0] word;
    model(pre, thr, trig_c, done_c, ok);
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_model: got no trigger expected trigger", tag);
      return;
    end
    start     = 1'b1;
    pre_count = PTR_W'(pre);
    threshold = 8'(thr);
    adc_valid = 1'b1;
    adc_data  = 8'hFF;
    tick();
    start = 1'b0;
    check({tag, "_trd_clr"}, 32'(trd), 32'd0);
    check({tag, "_cd_clr"},  32'(cd),  32'd0);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    for (int c = 0; c <= done_c; c++) begin
      adc_valid = vld[c];
      adc_data  = vld[c] ? samp[c] : 8'($urandom);
      start     = ($urandom_range(5) == 0);
      pre_count = PTR_W'($urandom);
      if (c == trig_c) check({tag, "_trd_pre"}, 32'(trd), 32'd0);
      tick();
      if (c == trig_c) begin
        check({tag, "_trd"},    32'(trd), 32'd1);
        check({tag, "_trigtm"}, trigtm,   32'(trig_c));
      end
    end
    adc_valid = 1'($urandom);
    adc_data  = 8'($urandom);
    check({tag, "_sdv_lat"}, 32'(sd_valid), 32'd0);
    check({tag, "_busy_snd"}, 32'(busy), 32'd1);
    tick();
    bad_v = 0;
    word  = '0;
    for (int i = 0; i < NBITS; i++) begin
      if (i == abort_bit) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        adc_valid = 1'b0;
        check_all_zero({tag, "_abort"});
        return;
      end
      if (!sd_valid) bad_v++;
      word = {word[6:0], sd};
      if (i % DATA_W == DATA_W - 1)
        check($sformatf("%s_w%0d", tag, i / DATA_W), 32'(word), 32'(exp_win[i / DATA_W]));
      adc_valid = 1'($urandom);
      adc_data  = 8'($urandom);
      start     = ($urandom_range(5) == 0);
      tick();
    end
    start     = 1'b0;
    adc_valid = 1'b0;
    check({tag, "_sdv_run"}, 32'(bad_v), 32'd0);
    check({tag, "_sdv_end"}, 32'(sd_valid), 32'd0);
    check({tag, "_sd_end"},  32'(sd), 32'd0);
    check({tag, "_cd"},      32'(cd), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_trd_hold"}, 32'(trd), 32'd1);
    check({tag, "_trigtm_hold"}, trigtm, 32'(trig_c));
    tick();
  endtask

  initial begin
    int thr;
    int pre;
    int trig_c;
    int done_c;
    bit ok;
    reset = 1'b1; start = 1'b0; adc_valid = 1'b0; adc_data = '0; threshold = '0; pre_count = '0;
    repeat (3) tick();
    check_all_zero("rst");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adc_valid = 1'($urandom);
      adc_data  = 8'($urandom);
      tick();
      if (i == 0 || i == 9) check_all_zero($sformatf("idle%0d", i));
    end
    adc_valid = 1'b0;

    gen_ramp();
    run_capture("ramp_d5", 8, 8'hD5, -1);
    gen_const(8'hFF);
    run_capture("const_ff", 8, 8'h10, -1);
    gen_ramp();
    run_capture("pre0", 0, 8'h40, -1);
    run_capture("pre31", 31, 8'h40, -1);
    run_capture("abort", 8, 8'hD5, 100);
    tick();
    run_capture("ramp_again", 8, 8'hD5, -1);

    gen_const(8'h00);
    samp[0] = 8'h90; samp[1] = 8'h90; samp[2] = 8'h70; samp[3] = 8'h85;
    run_capture("edge", 0, 8'h80, -1);

    for (int r = 0; r < 20; r++) begin
      gen_random();
      pre = $urandom_range(DEPTH - 1);
      ok  = 1'b0;
      for (int a = 0; a < 50 && !ok; a++) begin
        thr = $urandom_range(8'hE0, 1);
        model(pre, thr, trig_c, done_c, ok);
      end
      run_capture($sformatf("rnd%0d", r), pre, thr, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
